// File: rtl/contatore_pkg.sv
// rtl/contatore_pkg.sv - shared constants and parameter checks for counter/timer blocks
package contatore_pkg;

    // Values for the SATURATE parameter of the counting primitives
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // True when a count range 0..modulo-1 fits a width-bit register and has at least two states
    function automatic logic modulo_legal(input int width, input int modulo);
        longint span;
        if (width < 1 || width > 31) begin
            return 1'b0;
        end
        span = longint'(1) << width;
        return (modulo >= 2) && (longint'(modulo) <= span);
    endfunction

endpackage

// File: rtl/contatore_nbit.sv
// rtl/contatore_nbit.sv - parametrised up/down modulo counter with load and wrap/saturate
module contatore_nbit
    import contatore_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULO   = 16,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] out,
    output logic             ovf,
    output logic             zero
);

    // Refuse to elaborate a range that cannot be held in WIDTH bits
    generate
        if (!modulo_legal(WIDTH, MODULO)) begin : g_bad_params
            $error("contatore_nbit: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
        end
    endgenerate

    // Arithmetic runs one bit wider than the count so MODULO == 2**WIDTH needs no special case
    localparam logic [WIDTH:0] MOD_W    = (WIDTH+1)'(MODULO);
    localparam logic [WIDTH:0] TOP_W    = (WIDTH+1)'(MODULO - 1);
    localparam logic [WIDTH:0] ONE_W    = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] ZERO_W   = '0;
    localparam logic           SAT_MODE = (SATURATE == MODE_SAT);

    // Returns {boundary_event, next_count} for one edge, ignoring reset
    function automatic logic [WIDTH+1:0] next_value(
        input logic [WIDTH-1:0] cur,
        input logic             do_load,
        input logic             do_en,
        input logic             go_up,
        input logic [WIDTH-1:0] value
    );
        logic [WIDTH:0] cur_w;
        logic [WIDTH:0] val_w;
        logic [WIDTH:0] nxt_w;
        logic           hit;
        cur_w = {1'b0, cur};
        val_w = {1'b0, value};
        nxt_w = cur_w;
        hit   = 1'b0;
        if (do_load) begin
            // Out-of-range load values clamp to the top of the range
            nxt_w = (val_w < MOD_W) ? val_w : TOP_W;
        end else if (do_en && go_up) begin
            if (cur_w < TOP_W) begin
                nxt_w = cur_w + ONE_W;
            end else begin
                hit   = 1'b1;
                nxt_w = SAT_MODE ? TOP_W : ZERO_W;
            end
        end else if (do_en) begin
            if (cur_w != ZERO_W) begin
                nxt_w = cur_w - ONE_W;
            end else begin
                hit   = 1'b1;
                nxt_w = SAT_MODE ? ZERO_W : TOP_W;
            end
        end
        return {hit, nxt_w};
    endfunction

    logic [WIDTH+1:0] step;
    logic [WIDTH:0]   step_cnt;
    logic             step_ovf;

    assign step     = next_value(out, load, en, up, din);
    assign step_cnt = step[WIDTH:0];
    assign step_ovf = step[WIDTH+1];

    // Count register plus flags derived from the same next value, so zero always tracks out
    always_ff @(posedge clk) begin
        if (rst) begin
            out  <= '0;
            ovf  <= 1'b0;
            zero <= 1'b1;
        end else begin
            out  <= step_cnt[WIDTH-1:0];
            ovf  <= step_ovf;
            zero <= (step_cnt == ZERO_W);
        end
    end

endmodule

// File: tb/tb_contatore_nbit.sv
// tb/tb_contatore_nbit.sv - self-checking bench for contatore_nbit in wrap, saturate and full-range setups
module tb_contatore_nbit;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] din;
    logic [1:0] din2;

    logic [3:0] a_out;
    logic       a_ovf;
    logic       a_zero;
    logic [3:0] b_out;
    logic       b_ovf;
    logic       b_zero;
    logic [1:0] c_out;
    logic       c_ovf;
    logic       c_zero;

    int checks   = 0;
    int failures = 0;

    int ma = 0;
    int mb = 0;
    int mc = 0;
    bit ea_ovf;
    bit eb_ovf;
    bit ec_ovf;

    int dec_a[12]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int full_c[8]  = '{1, 2, 3, 0, 1, 2, 3, 0};
    int down_a[4]  = '{1, 0, 9, 8};
    int sat_ovf[3] = '{0, 1, 1};

    assign din2 = din[1:0];

    contatore_nbit #(.WIDTH(4), .MODULO(10), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
        .out(a_out), .ovf(a_ovf), .zero(a_zero)
    );

    contatore_nbit #(.WIDTH(4), .MODULO(10), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
        .out(b_out), .ovf(b_ovf), .zero(b_zero)
    );

    contatore_nbit #(.WIDTH(2), .MODULO(4), .SATURATE(0)) u_full (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din2),
        .out(c_out), .ovf(c_ovf), .zero(c_zero)
    );

    // Clock14-style free-running clock
    initial clk = 1'b0;
    always #7 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Counter behaviour in plain integer terms: step, then fold back into 0..mod-1 or pin to the bound
    function automatic void ref_step(inout int cur, output bit ov, input int mod, input bit sat,
                                     input bit r, input bit l, input bit e, input bit u, input int d);
        int want;
        ov = 1'b0;
        if (r) begin
            cur = 0;
        end else if (l) begin
            cur = (d < mod) ? d : mod - 1;
        end else if (e) begin
            want = u ? cur + 1 : cur - 1;
            if (want < 0 || want >= mod) begin
                ov  = 1'b1;
                cur = sat ? cur : ((want % mod) + mod) % mod;
            end else begin
                cur = want;
            end
        end
    endfunction

    task automatic cycle(input bit r, input bit l, input bit e, input bit u, input logic [3:0] d);
        rst  = r;
        load = l;
        en   = e;
        up   = u;
        din  = d;
        @(posedge clk);
        ref_step(ma, ea_ovf, 10, 1'b0, r, l, e, u, int'(d));
        ref_step(mb, eb_ovf, 10, 1'b1, r, l, e, u, int'(d));
        ref_step(mc, ec_ovf, 4, 1'b0, r, l, e, u, int'(d[1:0]));
        @(negedge clk);
        check_eq("wrap_out", int'(a_out), ma);
        check_eq("wrap_ovf", int'(a_ovf), int'(ea_ovf));
        check_eq("wrap_zero", int'(a_zero), int'(ma == 0));
        check_eq("sat_out", int'(b_out), mb);
        check_eq("sat_ovf", int'(b_ovf), int'(eb_ovf));
        check_eq("sat_zero", int'(b_zero), int'(mb == 0));
        check_eq("full_out", int'(c_out), mc);
        check_eq("full_ovf", int'(c_ovf), int'(ec_ovf));
        check_eq("full_zero", int'(c_zero), int'(mc == 0));
    endtask

    initial begin
        rst  = 1'b0;
        load = 1'b0;
        en   = 1'b0;
        up   = 1'b0;
        din  = '0;
        @(negedge clk);

        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
            check_eq("reset_out", int'(a_out), 0);
            check_eq("reset_ovf", int'(a_ovf), 0);
            check_eq("reset_zero", int'(a_zero), 1);
        end

        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
            check_eq("decade_out", int'(a_out), dec_a[i]);
            check_eq("decade_ovf", int'(a_ovf), (i == 9) ? 1 : 0);
            check_eq("decade_zero", int'(a_zero), (dec_a[i] == 0) ? 1 : 0);
            if (i < 8) begin
                check_eq("range_out", int'(c_out), full_c[i]);
                check_eq("range_ovf", int'(c_ovf), (i == 3 || i == 7) ? 1 : 0);
            end
        end

        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
        check_eq("load2_out", int'(a_out), 2);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
            check_eq("down_out", int'(a_out), down_a[i]);
            check_eq("down_ovf", int'(a_ovf), (i == 2) ? 1 : 0);
        end

        check_eq("midrst_pre", int'(c_out), 2);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
        check_eq("midrst_out", int'(c_out), 0);

        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd8);
        check_eq("satload_out", int'(b_out), 8);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
            check_eq("satup_out", int'(b_out), 9);
            check_eq("satup_ovf", int'(b_ovf), sat_ovf[i]);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check_eq("satdown_out", int'(b_out), 0);
        check_eq("satdown_ovf", int'(b_ovf), 1);

        cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'd13);
        check_eq("clamp_out", int'(a_out), 9);
        check_eq("clamp_ovf", int'(a_ovf), 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        check_eq("clamp_next_out", int'(a_out), 0);
        check_eq("clamp_next_ovf", int'(a_ovf), 1);

        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 39) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/contatore_nbit.md
# contatore_nbit

Parametrised synchronous up/down counter with modulus, parallel load and wrap or saturate mode. It generalises the fixed 2-bit counter to any width and count range. It serves as the general counting primitive for dividers, sequencers and timers in the design. All outputs are registered on a single clock.

## Interface
- `WIDTH`, default 4: counter width in bits; must be ≥1.
- `MODULO`, default 16: count range is 0..MODULO-1; must satisfy 2 ≤ MODULO ≤ 2**WIDTH.
- `SATURATE`, default 0: 0 selects wrap mode; 1 selects saturate mode (hold at the bound).

- `clk` in 1: clock; everything updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `en` in 1: count enable; 1 means one step per cycle.
- `up` in 1: direction; 1 counts up, 0 counts down. Ignored when `en`=0.
- `load` in 1: parallel load request.
- `din` in WIDTH: load value.
- `out` out WIDTH: current count.
- `ovf` out 1: one-cycle boundary-event flag.
- `zero` out 1: registered flag, high when the count is 0.

## Operation
- Priority per edge is `rst` > `load` > `en`. Otherwise `out` holds.
- **Reset:**
  - `out`=0, `ovf`=0, `zero`=1.
  - Applies regardless of `load` or `en`, including mid-count.
- **Load:**
  - `out` takes `din` if `din` < MODULO; otherwise it takes MODULO-1 (clamp).
  - `ovf`=0 on the load edge.
  - `en` and `up` are ignored on that edge.
- **Up step (`en`=1, `up`=1):**
  - If `out` < MODULO-1: `out`+1.
  - At MODULO-1 in wrap mode: `out` becomes 0 and `ovf`=1.
  - At MODULO-1 in saturate mode: `out` holds MODULO-1 and `ovf`=1.
- **Down step (`en`=1, `up`=0):**
  - If `out` > 0: `out`-1.
  - At 0 in wrap mode: `out` becomes MODULO-1 and `ovf`=1.
  - At 0 in saturate mode: `out` holds 0 and `ovf`=1.
- `ovf` is 0 on every edge that does not meet one of the boundary conditions above. It is a pulse, never sticky.
- `zero` is the registered result of (next `out` == 0). It is always consistent with `out` in the same cycle.
- **Arithmetic:**
  - Next-value computation is done in WIDTH+1 bits, so no silent modulo-2**WIDTH overflow occurs.
  - When MODULO == 2**WIDTH, wrap mode behaves as a plain binary counter.
- **Direction change:** a change of `up` between cycles takes effect on the same edge; there is no turnaround penalty.
- **Not a state machine:** the count register is the only state. The `ovf` and `zero` registers are derived from it.

## Timing
- Latency is one cycle: inputs sampled at edge N are visible on `out`, `ovf` and `zero` after edge N.
- Outputs have no combinational path from inputs.
- With `en` held high, `ovf` pulses exactly once every MODULO cycles in wrap mode, with either direction.
- In saturate mode with `en`=1 held at a bound, `ovf` is 1 on every such edge.
- `rst` deasserted at edge N: the first count step can happen at edge N+1.
- `load` and `en` asserted in the same cycle: the load wins and no step occurs on that edge.

## Structure
- Package `contatore_pkg` holds:
  - mode constants `MODE_WRAP`=0 and `MODE_SAT`=1;
  - the parameter-legality check (MODULO range versus WIDTH), reused by later timer blocks.
- There is no sub-module. The next-value logic is a single function inside `contatore_nbit`, followed by one registered process.
- The bench reuses the existing `Clock14` generator for `clk`.

## Test plan
Default bench settings are WIDTH=4, MODULO=10 unless a scenario states otherwise.
- **Reset:** `rst`=1 for 2 cycles with `en`=1 and `load`=1 → `out`=0, `ovf`=0, `zero`=1 on both edges.
- **Decade up, wrap:** `en`=1, `up`=1 for 12 cycles → `out` runs 1..9, 0, 1, 2; `ovf`=1 only on the cycle `out` returns to 0; `zero` matches.
- **Down, wrap:** load 2, then `en`=1, `up`=0 for 4 cycles → `out` runs 1, 0, 9, 8; `ovf` pulses with `out`=9.
- **Saturate (SATURATE=1):**
  - Load 8, then count up 3 cycles → `out` runs 9, 9, 9; `ovf` is 0, 1, 1.
  - Count down from 0 → `out` stays 0 and `ovf`=1.
- **Load clamp and priority:** `din`=13 with `load`=1, `en`=1, `up`=1 → `out`=9, `ovf`=0. Next cycle with `en` only → `out`=0, `ovf`=1.
- **Full range and mid-count reset:**
  - WIDTH=2, MODULO=4: count up 8 cycles → `out` runs 1, 2, 3, 0, 1, 2, 3, 0; `ovf` pulses twice.
  - Assert `rst` while `out`=2 → `out`=0 on the next edge.
